// File: rtl/sobel_frame_writer_pkg.sv
// Shared types and defaults for the sobel frame writer.
package sobel_frame_writer_pkg;

    localparam int IMG_WIDTH_DEF  = 720;
    localparam int IMG_HEIGHT_DEF = 540;
    localparam int DWIDTH_DEF     = 8;
    localparam int ADDR_WIDTH_DEF = 20;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Number of pixels in one frame.
    function automatic int frame_pixels(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/sobel_frame_writer_if.sv
// FIFO read side and memory write side of the sobel frame writer.
interface sobel_frame_writer_if #(
    parameter int DWIDTH     = 8,
    parameter int ADDR_WIDTH = 20
);
    logic                  fifo_in_rd_en;
    logic [DWIDTH-1:0]     fifo_in_dout;
    logic                  fifo_in_empty;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0]     mem_wdata;
    logic                  mem_ready;

    // The frame writer drains the FIFO and drives the memory.
    modport master (
        output fifo_in_rd_en,
        input  fifo_in_dout,
        input  fifo_in_empty,
        output mem_wr_en,
        output mem_addr,
        output mem_wdata,
        input  mem_ready
    );

    // The environment: FIFO read port and memory write port.
    modport slave (
        input  fifo_in_rd_en,
        output fifo_in_dout,
        output fifo_in_empty,
        input  mem_wr_en,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready
    );

endinterface

// File: rtl/sobel_frame_writer_raster_addr_counter.sv
// Raster-order address counter: running linear address plus row/col
// tracking used only to flag the final pixel of the frame.
module raster_addr_counter
    import sobel_frame_writer_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    // Advance col/row and the linear address together; wrap to 0 after the last pixel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (clear) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (inc) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
            addr <= last ? '0 : addr + ADDR_WIDTH'(1);
        end
    end

    // The address currently held is the last pixel of the frame.
    always_comb begin
        last = (row == ROW_LAST) && (col == COL_LAST);
    end

endmodule

// File: rtl/sobel_frame_writer.sv
// Drains the sobel FIFO (first-word-fall-through) and writes one frame of
// pixels to memory in raster order, one pixel per cycle when unstalled.
module sobel_frame_writer
    import sobel_frame_writer_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int DWIDTH     = DWIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           frame_count,
    sobel_frame_writer_if.master  bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
        ADDR_WIDTH'(frame_pixels(IMG_WIDTH, IMG_HEIGHT) - 1);

    state_t                state;
    state_t                state_nx;
    logic                  arm;
    logic                  issued_all;
    logic                  accept;
    logic                  vld_p0;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  last_pix;
    logic                  vld_p1;
    logic [ADDR_WIDTH-1:0] addr_p1;
    logic [DWIDTH-1:0]     data_p1;

    // ---- stage 0: pop decision from FIFO head ----
    always_comb begin
        arm    = (state == S_IDLE) && start;
        accept = vld_p1 && bus.mem_ready;
        vld_p0 = (state == S_RUN) && !bus.fifo_in_empty && !issued_all &&
                 (!vld_p1 || bus.mem_ready);
    end

    raster_addr_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr (
        .clock (clock),
        .reset (reset),
        .clear (arm),
        .inc   (vld_p0),
        .addr  (next_addr),
        .last  (last_pix)
    );

    // Remember that the final pixel has been popped so no further pops occur.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issued_all <= 1'b0;
        end else if (arm) begin
            issued_all <= 1'b0;
        end else if (vld_p0 && last_pix) begin
            issued_all <= 1'b1;
        end
    end

    // ---- stage 1: registered memory write, held while memory stalls ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else if (vld_p0) begin
            vld_p1  <= 1'b1;
            addr_p1 <= next_addr;
            data_p1 <= bus.fifo_in_dout;
        end else if (accept) begin
            vld_p1  <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state and status outputs; the frame ends when the last address is accepted.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (accept && (addr_p1 == LAST_ADDR)) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Count completed frames; wraps naturally at 16 bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
        end else if (state == S_DONE) begin
            frame_count <= frame_count + 16'd1;
        end
    end

    assign bus.fifo_in_rd_en = vld_p0;
    assign bus.mem_wr_en     = vld_p1;
    assign bus.mem_addr      = addr_p1;
    assign bus.mem_wdata     = data_p1;

endmodule

// File: tb/tb_sobel_frame_writer.sv
// Scoreboard bench for sobel_frame_writer on a 4x3 frame.
module tb_sobel_frame_writer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int N  = W * H;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] frame_count;

    sobel_frame_writer_if #(.DWIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sobel_frame_writer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .DWIDTH     (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .frame_count (frame_count),
        .bus         (bus)
    );

    always #5 clock = ~clock;

    int        checks   = 0;
    int        failures = 0;
    logic [7:0] fifo_q[$];
    wr_t       exp_q[$];
    bit        pop_lat  = 1'b0;
    int        accepts  = 0;
    logic      start_nx = 1'b0;
    logic      ready_nx = 1'b1;
    logic      rst_nx   = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // One clock: pop what the DUT took last edge, then drive this cycle's inputs.
    task automatic step();
        @(negedge clock);
        if (pop_lat && fifo_q.size() > 0) void'(fifo_q.pop_front());
        reset             = rst_nx;
        start             = start_nx;
        bus.mem_ready     = ready_nx;
        bus.fifo_in_empty = (fifo_q.size() == 0);
        bus.fifo_in_dout  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        #1;
        pop_lat = bus.fifo_in_rd_en;
    endtask

    task automatic load(input int first, input int n, input int base);
        wr_t e;
        for (int i = first; i < first + n; i++) begin
            fifo_q.push_back(8'(base + i));
            if (i < N) begin
                e.addr = AW'(i);
                e.data = DW'(base + i);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        rst_nx   = 1'b1;
        start_nx = 1'b0;
        ready_nx = 1'b1;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_rd_en", bus.fifo_in_rd_en, 0);
        chk("rst_wr_en", bus.mem_wr_en, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        step();
        fifo_q.delete();
        exp_q.delete();
        pop_lat = 1'b0;
        rst_nx  = 1'b0;
        step();
    endtask

    task automatic start_frame();
        start_nx = 1'b1;
        step();
        start_nx = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = -1;
        for (int k = 1; k <= budget; k++) begin
            step();
            if (done) begin
                cyc = k;
                break;
            end
        end
        if (cyc < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done required=done_within_%0d", budget);
        end
    endtask

    // Monitor: checks every accepted write against the scoreboard plus stall/done rules.
    bit            prev_stall    = 1'b0;
    bit            last_acc_prev = 1'b0;
    bit            done_prev     = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;
    int            exp_frames    = 0;

    always @(negedge clock) begin
        wr_t e;
        #2;
        if (reset) begin
            prev_stall    = 1'b0;
            last_acc_prev = 1'b0;
            done_prev     = 1'b0;
            exp_frames    = 0;
        end else begin
            if (done_prev) chk("frame_count_after_done", frame_count, exp_frames);
            if (done || last_acc_prev) chk("done_after_last_write", done, last_acc_prev);
            if (done) exp_frames++;
            done_prev = done;
            if (prev_stall) begin
                chk("hold_wr_en", bus.mem_wr_en, 1);
                chk("hold_addr", bus.mem_addr, prev_addr);
                chk("hold_wdata", bus.mem_wdata, prev_data);
            end
            if (bus.mem_wr_en && !bus.mem_ready) chk("no_pop_in_stall", bus.fifo_in_rd_en, 0);
            last_acc_prev = 1'b0;
            if (bus.mem_wr_en && bus.mem_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_write actual=addr_%0d required=no_write", bus.mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", bus.mem_addr, e.addr);
                    chk("wr_data", bus.mem_wdata, e.data);
                    accepts++;
                    last_acc_prev = (bus.mem_addr == AW'(N - 1));
                end
            end
            prev_stall = bus.mem_wr_en && !bus.mem_ready;
            prev_addr  = bus.mem_addr;
            prev_data  = bus.mem_wdata;
        end
    end

    initial begin
        int cyc;
        bus.mem_ready     = 1'b1;
        bus.fifo_in_empty = 1'b1;
        bus.fifo_in_dout  = '0;

        // 1: full-rate frame, done at cycle 14 counting the start cycle as 0.
        do_reset();
        load(0, 12, 8'h00);
        start_frame();
        chk("t1_busy_c0", busy, 0);
        step();
        chk("t1_busy_c1", busy, 1);
        chk("t1_rd_en_c1", bus.fifo_in_rd_en, 1);
        chk("t1_wr_en_c1", bus.mem_wr_en, 0);
        step();
        chk("t1_wr_en_c2", bus.mem_wr_en, 1);
        chk("t1_addr_c2", bus.mem_addr, 0);
        wait_done(40, cyc);
        chk("t1_done_cycle", 2 + cyc, 14);
        step();
        chk("t1_frame_count", frame_count, 1);
        chk("t1_busy_after", busy, 0);

        // 2: FIFO runs dry after six pixels for five cycles.
        do_reset();
        load(0, 6, 8'h20);
        start_frame();
        for (int k = 0; k < 20 && fifo_q.size() > 0; k++) step();
        for (int g = 0; g < 5; g++) begin
            step();
            chk("t2_gap_wr_en", bus.mem_wr_en, 0);
            chk("t2_gap_rd_en", bus.fifo_in_rd_en, 0);
        end
        load(6, 6, 8'h20);
        wait_done(40, cyc);
        step();
        chk("t2_frame_count", frame_count, 1);

        // 3: memory stalls three cycles while address 4 is pending.
        do_reset();
        load(0, 12, 8'h40);
        start_frame();
        for (int k = 1; k <= 5; k++) step();
        ready_nx = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t3_stall_wr_en", bus.mem_wr_en, 1);
            chk("t3_stall_addr", bus.mem_addr, 4);
            chk("t3_stall_data", bus.mem_wdata, 8'h44);
            chk("t3_stall_rd_en", bus.fifo_in_rd_en, 0);
        end
        ready_nx = 1'b1;
        wait_done(40, cyc);
        chk("t3_done_delay", cyc, 9);

        // 4: two surplus bytes stay in the FIFO.
        do_reset();
        load(0, 14, 8'h60);
        start_frame();
        wait_done(40, cyc);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_rd_en_after", bus.fifo_in_rd_en, 0);
        end
        chk("t4_fifo_left", fifo_q.size(), 2);
        if (fifo_q.size() > 0) chk("t4_fifo_head", fifo_q[0], 8'h6C);

        // 5: start during RUN and during DONE is ignored.
        do_reset();
        load(0, 12, 8'h80);
        start_frame();
        for (int k = 1; k <= 4; k++) step();
        start_nx = 1'b1;
        step();
        start_nx = 1'b0;
        chk("t5_busy_c5", busy, 1);
        for (int k = 6; k <= 13; k++) step();
        start_nx = 1'b1;
        step();
        start_nx = 1'b0;
        chk("t5_done_c14", done, 1);
        for (int k = 0; k < 6; k++) step();
        chk("t5_frame_count", frame_count, 1);
        chk("t5_busy_after", busy, 0);
        chk("t5_no_pending", exp_q.size(), 0);

        // 6: reset after seven writes, then a fresh frame.
        do_reset();
        accepts = 0;
        load(0, 12, 8'hA0);
        start_frame();
        for (int k = 0; k < 30 && accepts < 7; k++) step();
        chk("t6_partial_writes", accepts, 7);
        do_reset();
        accepts = 0;
        load(0, 12, 8'hC0);
        start_frame();
        wait_done(40, cyc);
        chk("t6_writes", accepts, 12);
        step();
        chk("t6_frame_count", frame_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
